// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO stream serializer.
// Entries carry the widest supported word; users slice down to DATA_WIDTH.
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } piso_state_e;

  // Widest word an SH/SK entry can carry.
  localparam int unsigned PisoMaxWidth = 64;

  typedef struct packed {
    logic                    msb_first;
    logic [PisoMaxWidth-1:0] data;
  } piso_entry_t;

  function automatic int unsigned calc_beats(input int unsigned data_width,
                                             input int unsigned lanes);
    return data_width / lanes;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/piso_skid_reg.sv
// One-entry skid buffer for the PISO serializer. Holds a word accepted while
// the shifter is busy; ready is registered as the inverse of the next full.
module piso_skid_reg
  import piso_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  piso_entry_t push_entry,
  input  logic        pop,
  output piso_entry_t entry,
  output logic        full,
  output logic        ready
);

  piso_entry_t entry_q;
  logic        full_q, full_d;
  logic        ready_q;

  // Next full flag; push and pop never coincide because ready is low when full
  always_comb begin
    full_d = full_q;
    if (full_q) begin
      full_d = ~pop;
    end else begin
      full_d = push;
    end
  end

  // Storage, full flag and registered ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry_q <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        entry_q <= push_entry;
      end
      full_q  <= full_d;
      ready_q <= ~full_d;
    end
  end

  assign entry = entry_q;
  assign full  = full_q;
  assign ready = ready_q;

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out stream serializer with a one-word skid buffer.
// Optional macro PISO_PARITY_EN appends an even-parity beat after each word.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  msb_first,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int unsigned     Beats   = calc_beats(DATA_WIDTH, LANES);
  localparam int unsigned     CntW    = calc_cnt_width(Beats);
  localparam logic [CntW-1:0] CntLast = CntW'(Beats - 1);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  msb_q, msb_d;
`ifdef PISO_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  accept, xfer, word_done;
  logic                  load_din, load_sk;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_msb;
  logic                  sk_push, sk_pop, sk_full;
  piso_entry_t           din_entry, sk_entry;
  logic                  unused_sk_data;

  assign accept    = din_valid & din_ready;
  assign xfer      = dout_valid & dout_ready;
  assign din_entry = '{msb_first: msb_first, data: PisoMaxWidth'(din)};
  // Entries are sized for the widest word; only the low DATA_WIDTH bits matter here.
  assign unused_sk_data = ^sk_entry.data;

  piso_skid_reg u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .push       (sk_push),
    .push_entry (din_entry),
    .pop        (sk_pop),
    .entry      (sk_entry),
    .full       (sk_full),
    .ready      (din_ready)
  );

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Shifter, beat counter and order flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      msb_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      msb_q    <= msb_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next state, shifter update and skid push/pop decisions
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    msb_d     = msb_q;
`ifdef PISO_PARITY_EN
    parity_d  = parity_q;
`endif
    word_done = 1'b0;
    load_din  = 1'b0;
    load_sk   = 1'b0;
    sk_pop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        load_din = accept;
      end
      StShift: begin
        if (xfer) begin
          if (cnt_q == CntLast) begin
`ifdef PISO_PARITY_EN
            state_d = StParity;
`else
            word_done = 1'b1;
`endif
          end else begin
            sh_d  = msb_q ? (sh_q << LANES) : (sh_q >> LANES);
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        word_done = xfer;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Final beat leaves: refill from the skid first, else pass din straight through
    if (word_done) begin
      if (sk_full) begin
        load_sk = 1'b1;
        sk_pop  = 1'b1;
      end else if (accept) begin
        load_din = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end

    sk_push = accept & (state_q != StIdle) & ~word_done;

    load_data = load_sk ? sk_entry.data[DATA_WIDTH-1:0] : din;
    load_msb  = load_sk ? sk_entry.msb_first : msb_first;
    if (load_din || load_sk) begin
      sh_d     = load_data;
      msb_d    = load_msb;
      cnt_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^load_data;
`endif
      state_d  = StShift;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StShift: begin
        dout_valid = 1'b1;
        dout       = msb_q ? sh_q[DATA_WIDTH-1 -: LANES] : sh_q[LANES-1:0];
`ifdef PISO_PARITY_EN
        dout_last  = 1'b0;
`else
        dout_last  = (cnt_q == CntLast);
`endif
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        dout_valid = 1'b1;
        dout       = LANES'(parity_q);
        dout_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle) | sk_full;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Self-checking bench for piso_stream_serializer. Two instances (8b x1 lane and
// 16b x4 lanes) share stimulus; sel picks which one is driven and observed.
module tb_piso_stream_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, sel;
  logic [15:0] din;
  logic        din_valid, msb_first, dout_ready;

  logic        din_ready_a, dout_valid_a, dout_last_a, busy_a;
  logic [0:0]  dout_a;
  logic        din_ready_b, dout_valid_b, dout_last_b, busy_b;
  logic [3:0]  dout_b;

  logic        cur_din_ready, cur_valid, cur_last, cur_busy;
  logic [3:0]  cur_dout;

  int          n_cmp = 0;
  int          n_fail = 0;

  logic [15:0] wq[$];
  bit          mq[$];
  logic [3:0]  exp_b[$];
  bit          exp_l[$];
  logic [31:0] seq;
  int          beat_cnt, last_cnt;
  bit          saw_not_ready;

  piso_stream_serializer #(.DATA_WIDTH(8), .LANES(1)) u_dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din[7:0]),
    .din_valid  (din_valid & ~sel),
    .din_ready  (din_ready_a),
    .msb_first  (msb_first),
    .dout       (dout_a),
    .dout_valid (dout_valid_a),
    .dout_ready (dout_ready),
    .dout_last  (dout_last_a),
    .busy       (busy_a)
  );

  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4)) u_dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid & sel),
    .din_ready  (din_ready_b),
    .msb_first  (msb_first),
    .dout       (dout_b),
    .dout_valid (dout_valid_b),
    .dout_ready (dout_ready),
    .dout_last  (dout_last_b),
    .busy       (busy_b)
  );

  always_comb begin
    cur_din_ready = sel ? din_ready_b  : din_ready_a;
    cur_valid     = sel ? dout_valid_b : dout_valid_a;
    cur_last      = sel ? dout_last_b  : dout_last_a;
    cur_busy      = sel ? busy_b       : busy_a;
    cur_dout      = sel ? dout_b       : {3'b000, dout_a};
  end

  function automatic int cur_dw();
    return sel ? 16 : 8;
  endfunction

  function automatic int cur_ln();
    return sel ? 4 : 1;
  endfunction

  // Reference: a word becomes BEATS slices of LANES bits in the chosen order,
  // optionally followed by one even-parity beat which carries the last flag.
  task automatic model_word(input logic [15:0] w, input bit msb);
    int dw = cur_dw();
    int ln = cur_ln();
    int beats = dw / ln;
    int mask = (1 << ln) - 1;
    int wm = int'(w) & ((1 << dw) - 1);
    for (int i = 0; i < beats; i++) begin
      int sh = msb ? (dw - ln * (i + 1)) : (ln * i);
      exp_b.push_back(4'((wm >> sh) & mask));
`ifdef PISO_PARITY_EN
      exp_l.push_back(1'b0);
`else
      exp_l.push_back(i == beats - 1);
`endif
    end
`ifdef PISO_PARITY_EN
    exp_b.push_back(4'(^wm));
    exp_l.push_back(1'b1);
`endif
  endtask

  // Streams wq/mq through the selected instance and scores every beat.
  // valid_mode: 0 hold valid, 1 random gaps. ready_mode: 0 always, 1 random, 2 1,0,0,1.
  task automatic stream(input int valid_mode, input int ready_mode, input bit check_gap,
                        input string name);
    int wi = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [3:0] prev_dout = '0;
    bit prev_last = 0;
    bit started = 0;
    bit done = 0;
    logic [3:0] eb;
    bit el;
    seq = '0; beat_cnt = 0; last_cnt = 0; saw_not_ready = 0;
    exp_b.delete(); exp_l.delete();
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        n_cmp++;
        if ({cur_valid, cur_dout, cur_last} !== {1'b1, prev_dout, prev_last}) begin
          n_fail++;
          $display("FAIL %s stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b", name,
                   cur_valid, cur_dout, cur_last, prev_dout, prev_last);
        end
      end
      if (wi == wq.size() && exp_b.size() == 0) begin
        done = 1;
      end else begin
        if (check_gap && started && exp_b.size() > 0) begin
          n_cmp++;
          if (cur_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s gap: got dout_valid=%b, want 1", name, cur_valid);
          end
        end
        if (!cur_din_ready) saw_not_ready = 1;
        if (wi < wq.size() && (valid_mode == 0 || $urandom_range(0, 9) < 7)) begin
          din = wq[wi]; msb_first = mq[wi]; din_valid = 1'b1;
        end else begin
          din = 16'($urandom); msb_first = 1'($urandom); din_valid = 1'b0;
        end
        case (ready_mode)
          0:       dout_ready = 1'b1;
          1:       dout_ready = 1'($urandom_range(0, 1));
          default: dout_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        endcase
        #1;
        if (cur_valid) begin
          started = 1;
          if (exp_b.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s spurious_beat: got d=%h, want no beat", name, cur_dout);
          end else if (dout_ready) begin
            eb = exp_b.pop_front();
            el = exp_l.pop_front();
            n_cmp++;
            if (cur_dout !== eb || cur_last !== el) begin
              n_fail++;
              $display("FAIL %s beat%0d: got d=%h l=%b, want d=%h l=%b", name, beat_cnt,
                       cur_dout, cur_last, eb, el);
            end
            seq = (seq << cur_ln()) | 32'(cur_dout);
            beat_cnt++;
            if (cur_last) last_cnt++;
          end
        end
        prev_stall = cur_valid && !dout_ready;
        prev_dout  = cur_dout;
        prev_last  = cur_last;
        if (din_valid && cur_din_ready) begin
          model_word(wq[wi], mq[wi]);
          wi++;
        end
      end
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d words/%0d beats left, want 0", name,
               wq.size() - wi, exp_b.size());
    end
    n_cmp++;
    if ({cur_valid, cur_busy, cur_din_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s end_idle: got v/busy/rdy=%b%b%b, want 001", name, cur_valid,
               cur_busy, cur_din_ready);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] want, input int beats);
    n_cmp++;
    if (seq !== want || beat_cnt != beats) begin
      n_fail++;
      $display("FAIL %s seq: got %h (%0d beats), want %h (%0d beats)", name, seq, beat_cnt,
               want, beats);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; sel = 1'b0; din = '0; din_valid = 1'b0; msb_first = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({din_ready_a, dout_valid_a, dout_last_a, busy_a, dout_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b, want 00000",
               {din_ready_a, dout_valid_a, dout_last_a, busy_a, dout_a});
    end
    n_cmp++;
    if ({din_ready_b, dout_valid_b, dout_last_b, busy_b, dout_b} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b, want 0", {din_ready_b, dout_valid_b, dout_last_b,
               busy_b, dout_b});
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({din_ready_a, busy_a, din_ready_b, busy_b} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/busy a=%b%b b=%b%b, want 10 10", din_ready_a,
               busy_a, din_ready_b, busy_b);
    end
  endtask

  task automatic test_latency();
    int n = 0;
    sel = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    din = 16'h00A5; msb_first = 1'b0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n_cmp++;
    if (cur_valid !== 1'b1 || cur_dout !== 4'h1) begin
      n_fail++;
      $display("FAIL latency: got v=%b d=%h one cycle after accept, want v=1 d=1",
               cur_valid, cur_dout);
    end
    dout_ready = 1'b1;
    while (cur_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (cur_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_drain: got busy=%b, want 0", cur_busy);
    end
  endtask

  task automatic test_order();
    sel = 1'b0; wq = '{16'h00A5}; mq = '{1'b0};
    stream(0, 0, 0, "lsb_a5");
`ifdef PISO_PARITY_EN
    check_seq("lsb_a5", 32'h14A, 9);
`else
    check_seq("lsb_a5", 32'hA5, 8);
`endif
    mq = '{1'b1};
    stream(0, 0, 0, "msb_a5");
`ifdef PISO_PARITY_EN
    check_seq("msb_a5", 32'h14A, 9);
`else
    check_seq("msb_a5", 32'hA5, 8);
`endif
    sel = 1'b1; wq = '{16'h1234}; mq = '{1'b1};
    stream(0, 0, 0, "msb_1234");
`ifdef PISO_PARITY_EN
    check_seq("msb_1234", 32'h12341, 5);
`else
    check_seq("msb_1234", 32'h1234, 4);
`endif
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; wq = '{16'h00FF, 16'h0000}; mq = '{1'b0, 1'b0};
    stream(0, 0, 1, "b2b");
`ifdef PISO_PARITY_EN
    check_seq("b2b", 32'h3FC00, 18);
`else
    check_seq("b2b", 32'hFF00, 16);
`endif
    n_cmp++;
    if (last_cnt != 2 || !saw_not_ready) begin
      n_fail++;
      $display("FAIL b2b_flags: got lasts=%0d ready_drop=%b, want 2 1", last_cnt,
               saw_not_ready);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b1; wq = '{16'hBEEF}; mq = '{1'b0};
    stream(0, 2, 0, "bp_beef");
`ifdef PISO_PARITY_EN
    check_seq("bp_beef", 32'hFEEB1, 5);
`else
    check_seq("bp_beef", 32'hFEEB, 4);
`endif
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; dout_ready = 1'b1;
    @(negedge clk);
    din = 16'h00A5; msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din = 16'h003C;
    @(negedge clk);
    din_valid = 1'b0;
    n_cmp++;
    if ({cur_valid, cur_din_ready, cur_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL rstmid_skid_full: got v/rdy/busy=%b%b%b, want 101", cur_valid,
               cur_din_ready, cur_busy);
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({cur_valid, cur_last, cur_busy, cur_din_ready, cur_dout} !== 8'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v/l/busy/rdy=%b%b%b%b d=%h, want 0000 0", cur_valid,
               cur_last, cur_busy, cur_din_ready, cur_dout);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cur_busy, cur_din_ready, cur_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL rstmid_release: got busy/rdy/v=%b%b%b, want 010", cur_busy,
               cur_din_ready, cur_valid);
    end
    repeat (4) begin
      @(negedge clk);
      if (cur_valid) saw_not_ready = 1;
    end
    wq = '{16'h005A}; mq = '{1'b1};
    stream(0, 0, 0, "rstmid_fresh");
`ifdef PISO_PARITY_EN
    check_seq("rstmid_fresh", 32'h0B4, 9);
`else
    check_seq("rstmid_fresh", 32'h5A, 8);
`endif
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    sel = 1'b0; wq = '{16'h0007}; mq = '{1'b0};
    stream(0, 0, 0, "parity_07");
    check_seq("parity_07", 32'h1C1, 9);
    wq = '{16'h0003};
    stream(0, 0, 0, "parity_03");
    check_seq("parity_03", 32'h180, 9);
  endtask
`endif

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      wq.delete(); mq.delete();
      for (int i = 0; i < 24; i++) begin
        wq.push_back(s == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom));
        mq.push_back(1'($urandom));
      end
      stream(1, 1, 0, "random_gaps");
      stream(0, 1, 0, "random_hold");
      stream(0, 0, 1, "random_b2b");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
